// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial addition sequencer. It adds two WIDTH-bit operands and a carry-in
// by time-sharing one external 1-bit full adder cell, one bit pair per clock,
// LSB first.
//
// A start handshake (start=1 while ready=1) latches a, b and ci. The sequencer
// then spends WIDTH cycles in RUN. In each RUN cycle it presents opa[0],
// opb[0] and the running carry to the adder cell. It recirculates add_co into
// the carry flop and shifts add_s into the MSB of the sum register. One DONE
// cycle follows, pulsing done, and the sequencer then returns to IDLE.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   request, accepted only while ready=1
//   a, b     in   WIDTH-bit operands, sampled on the accepting edge
//   ci       in   carry-in, sampled on the accepting edge
//   ready    out  high in IDLE
//   busy     out  high in RUN
//   done     out  one-cycle pulse; sum/co valid from this cycle on
//   sum      out  WIDTH-bit result, held until the next operation runs
//   co       out  final carry-out, held until the next operation completes
//   add_a    out  operand A bit to the adder cell
//   add_b    out  operand B bit to the adder cell
//   add_ci   out  carry to the adder cell
//   add_s    in   sum bit from the adder cell (combinational)
//   add_co   in   carry bit from the adder cell (combinational)
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             add_a,
    output logic             add_b,
    output logic             add_ci,
    input  logic             add_s,
    input  logic             add_co
);

    // One extra bit so the counter can represent WIDTH itself. This also
    // keeps the width at least 1 when WIDTH=1.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] opa_reg,   opa_next;
    logic [WIDTH-1:0] opb_reg,   opb_next;
    logic [WIDTH-1:0] sum_reg,   sum_next;
    logic             carry_reg, carry_next;
    logic             co_reg,    co_next;
    logic [CW-1:0]    cnt_reg,   cnt_next;

    // The sum is prepended with add_s and then shifted right by one. Taking
    // the upper WIDTH bits of this concatenation avoids a reversed part-select
    // when WIDTH=1.
    logic [WIDTH:0]   sum_shift;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            opa_reg   <= '0;
            opb_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            co_reg    <= co_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        co_next    = co_reg;
        cnt_next   = cnt_reg;
        sum_shift  = {add_s, sum_reg};

        case (state_reg)
            IDLE: begin
                if (start) begin
                    opa_next   = a;
                    opb_next   = b;
                    carry_next = ci;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end

            RUN: begin
                sum_next   = sum_shift[WIDTH:1];
                carry_next = add_co;
                opa_next   = opa_reg >> 1;
                opb_next   = opb_reg >> 1;
                cnt_next   = cnt_reg + CW'(1);
                // The last bit pair is being summed. Its carry-out is the
                // final carry of the whole addition.
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    co_next    = add_co;
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from registers, so the adder drive is glitch-free
    // and is forced low outside RUN.
    // -------------------------------------------------------------------------
    assign ready  = (state_reg == IDLE);
    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);
    assign sum    = sum_reg;
    assign co     = co_reg;
    assign add_a  = busy & opa_reg[0];
    assign add_b  = busy & opb_reg[0];
    assign add_ci = busy & carry_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Drives serial_add_ctrl with a gate-level full adder on the add_* ports.
// Every result is checked against the plain arithmetic sum a+b+ci. The bit
// presented to the adder in each RUN cycle is checked against the operand
// bits and the partial-sum carry. Directed cases cover start held high,
// operands changed mid-run and reset mid-run. Random operations follow.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;
    logic         ci_in = 1'b0;

    logic         ready, busy, done, co;
    logic [W-1:0] sum;
    logic         add_a, add_b, add_ci, add_s, add_co;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate-level 1-bit full adder cell.
    assign add_s  = add_a ^ add_b ^ add_ci;
    assign add_co = (add_a & add_b) | (add_ci & (add_a ^ add_b));

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a_in),
        .b      (b_in),
        .ci     (ci_in),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .co     (co),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ci (add_ci),
        .add_s  (add_s),
        .add_co (add_co)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the full (W+1)-bit result of a+b+ci.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Carry into bit i: bit i of (x mod 2^i) + (y mod 2^i) + c.
    function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input int i);
        longint unsigned m;
        longint unsigned t;
        m = (64'd1 << i) - 64'd1;
        t = (longint'(x) & m) + (longint'(y) & m) + longint'(c);
        return t[i];
    endfunction

    // One complete operation. With hold=1, start stays high after the accept.
    // With mid=1, the operands are replaced by na/nb/nci during RUN.
    // With expect_now=1, the accept must happen at the first edge.
    task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oci,
                      input bit hold, input bit mid,
                      input logic [W-1:0] na, input logic [W-1:0] nb, input logic nci,
                      input bit expect_now);
        int           waited;
        int           n;
        logic [W:0]   exp;
        a_in   = oa;
        b_in   = ob;
        ci_in  = oci;
        start  = 1'b1;
        waited = 0;
        while (ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (expect_now) check("accept_offset", 64'(waited), 64'd0);
        check("ready_before_accept", 64'(ready), 64'd1);
        tick();                         // accepting edge k; now in cycle k+1
        if (!hold) start = 1'b0;
        exp = ref_add(oa, ob, oci);
        n   = 1;
        while (done !== 1'b1 && n < 40) begin
            if (n <= W) begin
                check("run_busy",   64'(busy),   64'd1);
                check("run_ready",  64'(ready),  64'd0);
                check("run_add_a",  64'(add_a),  64'(oa[n-1]));
                check("run_add_b",  64'(add_b),  64'(ob[n-1]));
                check("run_add_ci", 64'(add_ci), 64'(carry_into(oa, ob, oci, n - 1)));
            end
            if (mid && n == 3) begin
                a_in  = na;
                b_in  = nb;
                ci_in = nci;
            end
            tick();
            n++;
        end
        check("done_latency", 64'(n), 64'(W + 1));
        check("done_sum",     64'(sum), 64'(exp[W-1:0]));
        check("done_co",      64'(co),  64'(exp[W]));
        check("done_busy",    64'(busy),  64'd0);
        check("done_ready",   64'(ready), 64'd0);
        check("done_add_bits", 64'({add_a, add_b, add_ci}), 64'd0);
        tick();
        check("post_ready",   64'(ready), 64'd1);
        check("post_done",    64'(done),  64'd0);
        check("post_sum",     64'(sum),   64'(exp[W-1:0]));
        check("post_co",      64'(co),    64'(exp[W]));
        $display("op a=%0h b=%0h ci=%0d -> sum=%0h co=%0d (ref %0h/%0d) latency=%0d",
                 oa, ob, oci, sum, co, exp[W-1:0], exp[W], n);
    endtask

    initial begin
        int seen;
        logic [W-1:0] ra, rb;
        logic         rc;

        // Reset with no clock edge yet: the state must clear asynchronously.
        #1 reset = 1'b1;
        #2;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_sum",   64'(sum),   64'd0);
        check("rst_co",    64'(co),    64'd0);
        check("rst_add",   64'({add_a, add_b, add_ci}), 64'd0);

        // start must be ignored while reset is high.
        start = 1'b1;
        a_in  = 8'h55;
        tick();
        tick();
        check("rst_start_ignored", 64'(busy), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();

        // Directed operations.
        op(8'h00, 8'h00, 1'b0, 0, 0, '0, '0, 1'b0, 1);
        op(8'hFF, 8'h01, 1'b0, 0, 0, '0, '0, 1'b0, 1);
        op(8'hA5, 8'h5A, 1'b1, 0, 0, '0, '0, 1'b0, 1);
        op(8'h3C, 8'h42, 1'b0, 0, 0, '0, '0, 1'b0, 1);

        // start held high and operands changed mid-run. The second operation
        // must be accepted on the first edge where ready=1 (edge k+W+2).
        op(8'hC3, 8'h2D, 1'b1, 1, 1, 8'h10, 8'h20, 1'b0, 1);
        op(8'h10, 8'h20, 1'b0, 0, 0, '0, '0, 1'b0, 1);

        // Reset in the 4th RUN cycle.
        a_in  = 8'h0F;
        b_in  = 8'h0F;
        ci_in = 1'b0;
        start = 1'b1;
        tick();                         // accept; cycle k+1
        start = 1'b0;
        tick();
        tick();
        tick();                         // cycle k+4
        check("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_busy",  64'(busy),  64'd0);
        check("abort_sum",   64'(sum),   64'd0);
        check("abort_co",    64'(co),    64'd0);
        check("abort_add",   64'({add_a, add_b, add_ci}), 64'd0);
        tick();
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_idle",    64'(ready), 64'd1);

        op(8'h01, 8'h02, 1'b1, 0, 0, '0, '0, 1'b0, 1);
        op(8'h01, 8'h01, 1'b1, 0, 0, '0, '0, 1'b0, 1);

        // Random operations against the arithmetic reference.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            op(ra, rb, rc, 0, 0, '0, '0, 1'b0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition sequencer that time-shares a single external 1-bit full adder (sum/carry cell) to add two WIDTH-bit operands plus carry-in. It latches the operands on a start handshake and presents one bit pair per clock to the adder, LSB first. It recirculates the adder's carry-out through a carry flip-flop and shifts the sum bits into a result register. It reports completion with a one-cycle done pulse. It sits between a requesting control unit and the shared 1-bit adder cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.

- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  operand A, sampled on the accepting edge.
- b  input  WIDTH  operand B, sampled on the accepting edge.
- ci  input  1  carry-in, sampled on the accepting edge.
- ready  output  1  high in IDLE; block can accept start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; sum/co valid.
- sum  output  WIDTH  result; holds its value until the next accepted start.
- co  output  1  final carry-out; holds its value until the next accepted start.
- add_a  output  1  bit of A to the adder cell.
- add_b  output  1  bit of B to the adder cell.
- add_ci  output  1  carry to the adder cell.
- add_s  input  1  sum bit from the adder cell, combinational from add_a/add_b/add_ci.
- add_co  input  1  carry bit from the adder cell, combinational from add_a/add_b/add_ci.

## Operation
- Internal state: opa/opb shift registers (WIDTH), carry flop, sum shift register (WIDTH), bit counter (ceil(log2(WIDTH))+1 bits), FSM {IDLE, RUN, DONE}.
- IDLE:
  - ready=1, busy=0, done=0.
  - start=1 at an edge loads opa=a, opb=b, carry=ci, cnt=0, then goes to RUN.
- RUN:
  - add_a=opa[0], add_b=opb[0], add_ci=carry, all driven from registers.
  - Each edge: sum shifts right with add_s entering the MSB; carry<=add_co; opa/opb shift right with 0 fill; cnt+1.
  - The edge with cnt==WIDTH-1 goes to DONE and copies carry<=add_co into co.
- DONE:
  - done=1 for exactly one cycle, then unconditionally IDLE.
  - sum[i] equals bit i of a+b+ci; co equals bit WIDTH of a+b+ci.
- add_a/add_b/add_ci are 0 in IDLE and DONE.
- start is ignored in RUN and DONE. It is not queued; the requester must re-assert it when ready=1.
- Arithmetic is unsigned modulo 2^WIDTH. The overflow is reported only through co.
- Reset (any time, including mid-RUN):
  - FSM enters IDLE immediately.
  - sum=0, co=0, carry=0, cnt=0, opa=opb=0.
  - ready=1, busy=0, done=0, add_a=add_b=add_ci=0.
  - An aborted operation produces no done pulse.
  - start is ignored while reset is high.

## Timing
- Start accepted at edge k (ready=1, start=1).
- busy=1 during cycles k+1 .. k+WIDTH. Bit i is presented to the adder in cycle k+1+i.
- done=1 during cycle k+WIDTH+1. sum/co are valid from that cycle onward.
- ready=1 again from cycle k+WIDTH+2. The earliest next accept is edge k+WIDTH+2.
- Start-to-done latency is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- WIDTH=1: one RUN cycle, done in cycle k+2.
- The adder path add_a/add_b/add_ci -> add_s/add_co is a single-cycle combinational path ending at the sum/carry flops.
- sum and co are registered and glitch-free. They change only during RUN and DONE entry, and on reset.

## Test plan
- Bench setup: instantiate a gate-level 1-bit full adder on the add_* ports, WIDTH=8, check every result against a+b+ci.
- After reset, start a=0x00 b=0x00 ci=0 -> sum=0x00, co=0, done exactly 9 cycles after the accepting edge, ready=1 one cycle later.
- a=0xFF b=0x01 ci=0 -> sum=0x00 co=1.
- a=0xA5 b=0x5A ci=1 -> sum=0x00 co=1.
- a=0x3C b=0x42 ci=0 -> sum=0x7E co=0.
- Hold start=1 continuously with new operands a=0x10 b=0x20 ci=0 applied mid-RUN -> the first result is unaffected.
  - The next accept occurs exactly at edge k+10.
  - The second result matches the operands present at that edge.
- Assert reset in the 4th RUN cycle of a=0x0F b=0x0F -> ready=1, busy=0, sum=0x00, co=0 immediately, no done pulse.
- Then a=0x01 b=0x02 ci=1 -> sum=0x04 co=0.
- WIDTH=1 build: a=1 b=1 ci=1 -> sum=1 co=1, done 2 cycles after accept.
